// File: rtl/fp_div_pkg.sv
// Shared types, widths and helpers for the sequential floating-point divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StRound,
        StDone
    } state_e;

    // Bit positions inside the {invalid, divzero, overflow, underflow, inexact} flag vector.
    localparam int unsigned FlagInvalid   = 4;
    localparam int unsigned FlagDivZero   = 3;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagInexact   = 0;

    function automatic int unsigned fp_width(input int unsigned nx, input int unsigned nm);
        return 1 + nx + nm;
    endfunction

    function automatic int unsigned fp_bias(input int unsigned nx);
        return (32'd1 << (nx - 1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_exp_max(input int unsigned nx);
        return (32'd1 << nx) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational round-to-nearest-even, renormalise and pack stage (shared with a future sqrt).
// Flag outputs exist only when FP_DIV_FLAGS_EN is defined.
module fp_div_round import fp_div_pkg::*; #(
    parameter int unsigned NX = 8,
    parameter int unsigned NM = 23
) (
    input  logic                        i_sign,
    input  logic [NX+1:0]               i_exp,
    input  logic [NM:0]                 i_sig,
    input  logic                        i_guard,
    input  logic                        i_sticky,
    output logic [fp_width(NX, NM)-1:0] o_res
`ifdef FP_DIV_FLAGS_EN
    ,
    output logic [4:0]                  o_flags
`endif
);

    localparam logic [NX:0] ExpMax = (NX+1)'(fp_exp_max(NX));

    logic          w_round_up;
    logic [NM+1:0] w_sum;
    logic [NX+1:0] w_exp;
    logic [NM-1:0] w_frac;
    logic          w_ovf;
    logic          w_unf;

    always_comb begin
        w_round_up = i_guard & (i_sticky | i_sig[0]);
        w_sum      = {1'b0, i_sig} + {{(NM+1){1'b0}}, w_round_up};
        // Carry-out means the significand rounded up to 2.0; the fraction becomes zero.
        if (w_sum[NM+1]) begin
            w_frac = w_sum[NM:1];
            w_exp  = i_exp + (NX+2)'(1);
        end else begin
            w_frac = w_sum[NM-1:0];
            w_exp  = i_exp;
        end
        // i_exp is two's complement; the top bit flags a negative exponent.
        w_ovf = !w_exp[NX+1] && (w_exp[NX:0] >= ExpMax);
        w_unf = w_exp[NX+1] || (w_exp == '0);
        if (w_ovf) begin
            o_res = {i_sign, {NX{1'b1}}, {NM{1'b0}}};
        end else if (w_unf) begin
            o_res = {i_sign, {(NX+NM){1'b0}}};
        end else begin
            o_res = {i_sign, w_exp[NX-1:0], w_frac};
        end
    end

`ifdef FP_DIV_FLAGS_EN
    always_comb begin
        o_flags                = '0;
        o_flags[FlagOverflow]  = w_ovf;
        o_flags[FlagUnderflow] = w_unf;
        o_flags[FlagInexact]   = i_guard | i_sticky | w_ovf | w_unf;
    end
`endif

endmodule

// File: rtl/fp_seq_div.sv
// Multi-cycle restoring floating-point divider, one quotient bit per clock, ready/valid on both sides.
// Define FP_DIV_FLAGS_EN to add the out_flags port and exception flag logic.
module fp_seq_div import fp_div_pkg::*; #(
    parameter int unsigned NX = 8,
    parameter int unsigned NM = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [fp_width(NX, NM)-1:0] in_a,
    input  logic [fp_width(NX, NM)-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [fp_width(NX, NM)-1:0] out_q
`ifdef FP_DIV_FLAGS_EN
    ,
    output logic [4:0]                  out_flags
`endif
);

    localparam int unsigned     W        = fp_width(NX, NM);
    localparam int unsigned     CntW     = $clog2(NM + 3);
    localparam logic [CntW-1:0] LastIter = CntW'(NM + 2);
    localparam logic [NX+1:0]   Bias     = (NX+2)'(fp_bias(NX));
    localparam logic [W-1:0]    QNan     = {1'b0, {NX{1'b1}}, 1'b1, {(NM-1){1'b0}}};

    state_e          r_state;
    logic            r_pend;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_out_q;
    logic [NM+1:0]   r_rem;
    logic [NM+2:0]   r_quo;
    logic [CntW-1:0] r_cnt;
    logic [NX+1:0]   r_exp;

    logic [NX-1:0]   w_ea;
    logic [NX-1:0]   w_eb;
    logic [NM-1:0]   w_fa;
    logic [NM-1:0]   w_fb;
    logic            w_sign;
    logic            w_a_zero;
    logic            w_b_zero;
    logic            w_a_inf;
    logic            w_b_inf;
    logic            w_nan_res;
    logic            w_inf_res;
    logic            w_zero_res;
    logic            w_div_zero;
    logic            w_special;
    logic [W-1:0]    w_spec_q;

    logic [NM+1:0]   w_mb;
    logic            w_ge;
    logic [NM:0]     w_diff;
    logic [NM:0]     w_sig;
    logic            w_guard;
    logic            w_sticky;
    logic [NX+1:0]   w_rexp;
    logic [W-1:0]    w_rnd_q;

    // Operand classification; subnormals (exp == 0) count as zero.
    always_comb begin
        w_ea       = r_a[NX+NM-1:NM];
        w_eb       = r_b[NX+NM-1:NM];
        w_fa       = r_a[NM-1:0];
        w_fb       = r_b[NM-1:0];
        w_sign     = r_a[W-1] ^ r_b[W-1];
        w_a_zero   = (w_ea == '0);
        w_b_zero   = (w_eb == '0);
        w_a_inf    = (w_ea == '1) && (w_fa == '0);
        w_b_inf    = (w_eb == '1) && (w_fb == '0);
        w_nan_res  = ((w_ea == '1) && (w_fa != '0)) || ((w_eb == '1) && (w_fb != '0)) ||
                     (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
        w_inf_res  = !w_nan_res && (w_a_inf || w_b_zero);
        w_div_zero = !w_nan_res && !w_a_inf && w_b_zero;
        w_zero_res = !w_nan_res && !w_inf_res && (w_a_zero || w_b_inf);
        w_special  = w_nan_res || w_inf_res || w_zero_res;
        if (w_nan_res) begin
            w_spec_q = QNan;
        end else if (w_inf_res) begin
            w_spec_q = {w_sign, {NX{1'b1}}, {NM{1'b0}}};
        end else begin
            w_spec_q = {w_sign, {(NX+NM){1'b0}}};
        end
    end

    always_comb begin
        w_mb   = {2'b01, w_fb};
        w_ge   = (r_rem >= w_mb);
        w_diff = w_ge ? (NM+1)'(r_rem - w_mb) : r_rem[NM:0];
        // A leading zero quotient bit means ma < mb: take one more bit and drop the exponent.
        if (r_quo[NM+2]) begin
            w_sig    = r_quo[NM+2:2];
            w_guard  = r_quo[1];
            w_sticky = (r_rem != '0) | r_quo[0];
            w_rexp   = r_exp;
        end else begin
            w_sig    = r_quo[NM+1:1];
            w_guard  = r_quo[0];
            w_sticky = (r_rem != '0);
            w_rexp   = r_exp - (NX+2)'(1);
        end
    end

`ifdef FP_DIV_FLAGS_EN
    logic [4:0] w_spec_flags;
    logic [4:0] w_rnd_flags;
    logic [4:0] r_flags;

    always_comb begin
        w_spec_flags              = '0;
        w_spec_flags[FlagInvalid] = w_nan_res;
        w_spec_flags[FlagDivZero] = w_div_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (r_state == StIdle && r_pend && w_special) begin
            r_flags <= w_spec_flags;
        end else if (r_state == StRound) begin
            r_flags <= w_rnd_flags;
        end else if (r_state == StDone && out_ready) begin
            r_flags <= '0;
        end
    end

    assign out_flags = r_flags;
`else
    logic w_unused;
    assign w_unused = w_div_zero;
`endif

    fp_div_round #(
        .NX (NX),
        .NM (NM)
    ) u_round (
        .i_sign   (w_sign),
        .i_exp    (w_rexp),
        .i_sig    (w_sig),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .o_res    (w_rnd_q)
`ifdef FP_DIV_FLAGS_EN
        ,
        .o_flags  (w_rnd_flags)
`endif
    );

    // Operands are captured on accept and classified one cycle later (r_pend).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_pend      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_q     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_pend) begin
                        r_pend <= 1'b0;
                        if (w_special) begin
                            r_out_q     <= w_spec_q;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_rem   <= {2'b01, w_fa};
                            r_quo   <= '0;
                            r_cnt   <= '0;
                            r_exp   <= {2'b00, w_ea} - {2'b00, w_eb} + Bias;
                            r_state <= StIter;
                        end
                    end else if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_pend     <= 1'b1;
                        r_in_ready <= 1'b0;
                    end
                end
                StIter: begin
                    r_rem <= {w_diff, 1'b0};
                    r_quo <= {r_quo[NM+1:0], w_ge};
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == LastIter) begin
                        r_state <= StRound;
                    end
                end
                StRound: begin
                    r_out_q     <= w_rnd_q;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;

endmodule
